// File: rtl/input_conditioner.sv
// Pad-side conditioner for one asynchronous pin: two-flop synchronizer, saturating
// stability-counter debounce, and registered one-cycle rise/fall strobes.
module input_conditioner #(
  parameter int counterwidth = 3,
  parameter int waittime     = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic noisysignal,
  output logic conditioned,
  output logic positiveedge,
  output logic negativeedge
);

  // The counter saturates at waittime, so waittime must fit in counterwidth bits.
  if (waittime < 0 || waittime > (1 << counterwidth) - 1) begin : gIllegalWaittime
    $error("input_conditioner: waittime %0d does not fit in %0d counter bits",
           waittime, counterwidth);
  end

  localparam logic [counterwidth-1:0] waitCount = counterwidth'(waittime);

  logic                    sync0;
  logic                    sync1;
  logic [counterwidth-1:0] counter;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync0        <= 1'b0;
      sync1        <= 1'b0;
      counter      <= '0;
      conditioned  <= 1'b0;
      positiveedge <= 1'b0;
      negativeedge <= 1'b0;
    end else begin
      sync0        <= noisysignal;
      sync1        <= sync0;
      positiveedge <= 1'b0;
      negativeedge <= 1'b0;
      // Debounce decisions use the pre-edge synchronized level.
      if (sync1 == conditioned) begin
        counter <= '0;
      end else if (counter == waitCount) begin
        conditioned  <= sync1;
        counter      <= '0;
        positiveedge <= sync1;
        negativeedge <= ~sync1;
      end else begin
        counter <= counter + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner: a per-cycle vector table for the default
// configuration plus short hand sequences for the waittime=0 and waittime=7 builds.
module tb_input_conditioner;

  typedef struct {
    string name;
    bit    rst;
    bit    noisy;
    bit    expCond;
    bit    expPos;
    bit    expNeg;
  } vec_t;

  logic clk;
  logic reset;
  logic noisyD, noisy0, noisy7;
  logic condD, posD, negD;
  logic cond0, pos0, neg0;
  logic cond7, pos7, neg7;

  int total  = 0;
  int passed = 0;

  vec_t vecs[$];

  input_conditioner dutDefault (
    .clk(clk), .reset(reset), .noisysignal(noisyD),
    .conditioned(condD), .positiveedge(posD), .negativeedge(negD)
  );

  input_conditioner #(.counterwidth(1), .waittime(0)) dutWait0 (
    .clk(clk), .reset(reset), .noisysignal(noisy0),
    .conditioned(cond0), .positiveedge(pos0), .negativeedge(neg0)
  );

  input_conditioner #(.counterwidth(3), .waittime(7)) dutWait7 (
    .clk(clk), .reset(reset), .noisysignal(noisy7),
    .conditioned(cond7), .positiveedge(pos7), .negativeedge(neg7)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic act, input logic exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b required %b", nm, act, exp);
  endtask

  task automatic add(input string nm, input bit r, input bit n,
                     input bit c, input bit p, input bit ng, input int reps);
    vec_t v;
    for (int i = 0; i < reps; i++) begin
      v.name = nm; v.rst = r; v.noisy = n;
      v.expCond = c; v.expPos = p; v.expNeg = ng;
      vecs.push_back(v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset  = 1'b1;
    noisyD = 1'b0;
    noisy0 = 1'b0;
    noisy7 = 1'b0;

    // Each row: inputs held through one edge, outputs expected after that edge.
    add("rst",      1, 1, 0, 0, 0, 2);
    add("rstRel",   0, 1, 0, 0, 0, 5);
    add("rstRise",  0, 1, 1, 1, 0, 1);
    add("rstHold",  0, 1, 1, 0, 0, 2);
    add("fall",     0, 0, 1, 0, 0, 5);
    add("fallEdge", 0, 0, 0, 0, 1, 1);
    add("fallHold", 0, 0, 0, 0, 0, 3);
    for (int w = 1; w <= 3; w++) begin
      add($sformatf("glitch%0dHi", w), 0, 1, 0, 0, 0, w);
      add($sformatf("glitch%0dLo", w), 0, 0, 0, 0, 0, 10);
    end
    add("pulse4Hi",   0, 1, 0, 0, 0, 4);
    add("pulse4Lo",   0, 0, 0, 0, 0, 1);
    add("pulse4Rise", 0, 0, 1, 1, 0, 1);
    add("pulse4Body", 0, 0, 1, 0, 0, 3);
    add("pulse4Fall", 0, 0, 0, 0, 1, 1);
    add("pulse4Idle", 0, 0, 0, 0, 0, 5);
    begin
      bit pat[10] = '{1, 0, 1, 1, 0, 1, 1, 1, 1, 1};
      foreach (pat[i]) add("bounce", 0, pat[i], 0, 0, 0, 1);
    end
    add("bounceRise", 0, 1, 1, 1, 0, 1);
    add("bounceHold", 0, 1, 1, 0, 0, 3);
    add("bounceDrop", 0, 0, 1, 0, 0, 5);
    add("bounceFall", 0, 0, 0, 0, 1, 1);
    add("bounceIdle", 0, 0, 0, 0, 0, 3);
    add("midRise",    0, 1, 0, 0, 0, 3);
    add("midReset",   1, 1, 0, 0, 0, 1);
    add("midRelease", 0, 1, 0, 0, 0, 5);
    add("midAccept",  0, 1, 1, 1, 0, 1);
    add("midHold",    0, 1, 1, 0, 0, 2);

    foreach (vecs[i]) begin
      reset  = vecs[i].rst;
      noisyD = vecs[i].noisy;
      tick();
      chk($sformatf("%s[%0d].cond", vecs[i].name, i), condD, vecs[i].expCond);
      chk($sformatf("%s[%0d].pos",  vecs[i].name, i), posD,  vecs[i].expPos);
      chk($sformatf("%s[%0d].neg",  vecs[i].name, i), negD,  vecs[i].expNeg);
      chk($sformatf("%s[%0d].excl", vecs[i].name, i), posD & negD, 1'b0);
    end
    reset = 1'b0;

    // waittime = 0: step reaches conditioned at E2, single-cycle pulse passes.
    noisy0 = 1'b1;
    tick(); chk("w0StepE0.cond", cond0, 1'b0);
    tick(); chk("w0StepE1.cond", cond0, 1'b0);
    tick(); chk("w0StepE2.cond", cond0, 1'b1); chk("w0StepE2.pos", pos0, 1'b1);
    tick(); chk("w0StepE3.cond", cond0, 1'b1); chk("w0StepE3.pos", pos0, 1'b0);
    noisy0 = 1'b0;
    tick(); tick(); chk("w0DropE1.cond", cond0, 1'b1);
    tick(); chk("w0DropE2.cond", cond0, 1'b0); chk("w0DropE2.neg", neg0, 1'b1);
    tick(); chk("w0DropE3.neg", neg0, 1'b0);
    noisy0 = 1'b1;
    tick();
    noisy0 = 1'b0;
    tick(); chk("w0PulseE1.cond", cond0, 1'b0);
    tick(); chk("w0PulseE2.cond", cond0, 1'b1); chk("w0PulseE2.pos", pos0, 1'b1);
    tick(); chk("w0PulseE3.cond", cond0, 1'b0); chk("w0PulseE3.neg", neg0, 1'b1);
    chk("w0PulseE3.pos", pos0, 1'b0);
    tick(); chk("w0PulseE4.neg", neg0, 1'b0); chk("w0PulseE4.cond", cond0, 1'b0);

    // waittime = 7: step reaches conditioned at E9, 7-cycle pulse rejected.
    noisy7 = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      tick();
      chk($sformatf("w7Rise[%0d].cond", k), cond7, (k >= 9));
      chk($sformatf("w7Rise[%0d].pos",  k), pos7,  (k == 9));
    end
    noisy7 = 1'b0;
    for (int k = 0; k <= 10; k++) begin
      tick();
      chk($sformatf("w7Fall[%0d].cond", k), cond7, (k < 9));
      chk($sformatf("w7Fall[%0d].neg",  k), neg7,  (k == 9));
    end
    for (int k = 0; k < 25; k++) begin
      noisy7 = (k < 7);
      tick();
      chk($sformatf("w7Pulse7[%0d].cond", k), cond7, 1'b0);
      chk($sformatf("w7Pulse7[%0d].pos",  k), pos7,  1'b0);
      chk($sformatf("w7Pulse7[%0d].neg",  k), neg7,  1'b0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
